// File: rtl/debug_led_bank.sv
// Multi-channel debug indicator: edge-detected events drive LEDs in stretch,
// sticky, toggle or blink mode, each channel with a saturating event counter.
module debug_led_bank #(
    parameter int unsigned CHANNELS   = 8,
    parameter int unsigned HOLD_TICKS = 2,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      tick,
    input  logic [CHANNELS-1:0]       event_in,
    input  logic [1:0]                mode,
    input  logic                      clear,
    output logic [CHANNELS-1:0]       led_out,
    output logic [CHANNELS*CNT_W-1:0] event_cnt,
    output logic                      any_active
);

    localparam int unsigned TW = $clog2(HOLD_TICKS + 1);
    localparam logic [TW-1:0]    HOLD    = TW'(HOLD_TICKS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [1:0] MODE_STRETCH = 2'b00;
    localparam logic [1:0] MODE_STICKY  = 2'b01;
    localparam logic [1:0] MODE_TOGGLE  = 2'b10;
    localparam logic [1:0] MODE_BLINK   = 2'b11;

    logic [CHANNELS-1:0] prev;
    logic [CHANNELS-1:0] evt;
    logic [CHANNELS-1:0] latch;
    logic [TW-1:0]       timer [CHANNELS];
    logic [CNT_W-1:0]    cnt   [CHANNELS];
    logic                phase;

    assign evt = event_in & ~prev;

    // Edge-detect history and shared blink phase; neither is touched by clear
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            prev  <= '0;
            phase <= 1'b1;
        end else begin
            prev <= event_in;
            if (tick) begin
                phase <= ~phase;
            end
        end
    end

    // Per-channel hold timer, latch and saturating counter
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            latch <= '0;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                timer[i] <= '0;
                cnt[i]   <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (clear) begin
                    timer[i] <= '0;
                    latch[i] <= 1'b0;
                    cnt[i]   <= '0;
                end else begin
                    // Reload beats a coincident tick so the new hold is full length
                    if (evt[i]) begin
                        timer[i] <= HOLD;
                    end else if (tick && (timer[i] != '0)) begin
                        timer[i] <= timer[i] - TW'(1);
                    end

                    if (evt[i] && (mode == MODE_STICKY)) begin
                        latch[i] <= 1'b1;
                    end else if (evt[i] && (mode == MODE_TOGGLE)) begin
                        latch[i] <= ~latch[i];
                    end

                    if (evt[i] && (cnt[i] != CNT_MAX)) begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // LED view follows the live mode without altering stored state
    always_comb begin
        led_out = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            case (mode)
                MODE_STRETCH: led_out[i] = (timer[i] != '0);
                MODE_STICKY:  led_out[i] = latch[i];
                MODE_TOGGLE:  led_out[i] = latch[i];
                MODE_BLINK:   led_out[i] = (timer[i] != '0) & phase;
                default:      led_out[i] = 1'b0;
            endcase
        end
    end

    always_comb begin
        event_cnt = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            event_cnt[i*CNT_W +: CNT_W] = cnt[i];
        end
    end

    assign any_active = |led_out;

endmodule

// File: tb/tb_debug_led_bank.sv
// Bench for debug_led_bank: two instances (hold 2 and hold 4, 3-bit counters)
// share stimulus and are compared every cycle against a tick-counting model.
module tb_debug_led_bank;

    localparam int CH = 8;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          resetN;
    logic          tick;
    logic [CH-1:0] event_in;
    logic [1:0]    mode;
    logic          clear;
    logic [CH-1:0]      led_a, led_b;
    logic [CH*CW-1:0]   cnt_a, cnt_b;
    logic               any_a, any_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    debug_led_bank #(.CHANNELS(CH), .HOLD_TICKS(2), .CNT_W(CW)) u_h2 (
        .clk(clk), .resetN(resetN), .tick(tick), .event_in(event_in),
        .mode(mode), .clear(clear), .led_out(led_a), .event_cnt(cnt_a),
        .any_active(any_a)
    );

    debug_led_bank #(.CHANNELS(CH), .HOLD_TICKS(4), .CNT_W(CW)) u_h4 (
        .clk(clk), .resetN(resetN), .tick(tick), .event_in(event_in),
        .mode(mode), .clear(clear), .led_out(led_b), .event_cnt(cnt_b),
        .any_active(any_b)
    );

    // Model: per channel, whether an event was seen since clear/reset and how
    // many ticks have passed strictly after it; the LED is lit while ticks < hold.
    bit m_prev  [CH];
    bit m_ever  [CH];
    int m_ticks [CH];
    bit m_latch [CH];
    int m_cnt   [CH];
    bit m_phase;

    function automatic void model_reset();
        for (int i = 0; i < CH; i++) begin
            m_prev[i] = 0; m_ever[i] = 0; m_ticks[i] = 0;
            m_latch[i] = 0; m_cnt[i] = 0;
        end
        m_phase = 1;
    endfunction

    function automatic void model_edge();
        if (!resetN) return;
        for (int i = 0; i < CH; i++) begin
            bit e;
            e = event_in[i] && !m_prev[i];
            if (clear) begin
                m_ever[i] = 0; m_ticks[i] = 0; m_latch[i] = 0; m_cnt[i] = 0;
            end else if (e) begin
                m_ever[i]  = 1;
                m_ticks[i] = 0;
                if (mode == 2'd1) m_latch[i] = 1;
                if (mode == 2'd2) m_latch[i] = !m_latch[i];
                if (m_cnt[i] < (1 << CW) - 1) m_cnt[i]++;
            end else if (tick && m_ever[i] && m_ticks[i] < 1000) begin
                m_ticks[i]++;
            end
            m_prev[i] = event_in[i];
        end
        if (tick) m_phase = !m_phase;
    endfunction

    function automatic logic [CH-1:0] exp_led(input int hold);
        logic [CH-1:0] v;
        v = '0;
        for (int i = 0; i < CH; i++) begin
            bit lit;
            lit = m_ever[i] && (m_ticks[i] < hold);
            case (mode)
                2'd0:    v[i] = lit;
                2'd1:    v[i] = m_latch[i];
                2'd2:    v[i] = m_latch[i];
                default: v[i] = lit && m_phase;
            endcase
        end
        return v;
    endfunction

    function automatic logic [CH*CW-1:0] exp_cnt();
        logic [CH*CW-1:0] v;
        for (int i = 0; i < CH; i++) v[i*CW +: CW] = CW'(m_cnt[i]);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [CH-1:0] ea, eb;
        ea = exp_led(2);
        eb = exp_led(4);
        chk("led_h2", 32'(led_a), 32'(ea));
        chk("led_h4", 32'(led_b), 32'(eb));
        chk("cnt_h2", 32'(cnt_a), 32'(exp_cnt()));
        chk("cnt_h4", 32'(cnt_b), 32'(exp_cnt()));
        chk("any_h2", 32'(any_a), 32'(|ea));
        chk("any_h4", 32'(any_b), 32'(|eb));
    endtask

    // Drive one cycle's inputs at the falling edge, check, then clock once
    task automatic step(input logic [CH-1:0] ev, input logic [1:0] md,
                        input logic clr, input logic tk);
        event_in = ev; mode = md; clear = clr; tick = tk;
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    function automatic logic [CW-1:0] ch_cnt(input logic [CH*CW-1:0] v, input int i);
        return v[i*CW +: CW];
    endfunction

    typedef struct {
        logic [CH-1:0] ev;
        logic [1:0]    md;
        logic          clr;
        logic          exp_led1;
        logic [CW-1:0] exp_cnt1;
    } vec_t;

    vec_t tbl [11];

    initial begin
        // Toggle/sticky vectors on channel 1; expectations are after each row's edge
        tbl[0]  = '{8'h02, 2'd2, 1'b0, 1'b1, 3'd1};
        tbl[1]  = '{8'h00, 2'd2, 1'b0, 1'b1, 3'd1};
        tbl[2]  = '{8'h02, 2'd2, 1'b0, 1'b0, 3'd2};
        tbl[3]  = '{8'h00, 2'd2, 1'b0, 1'b0, 3'd2};
        tbl[4]  = '{8'h02, 2'd2, 1'b0, 1'b1, 3'd3};
        tbl[5]  = '{8'h00, 2'd2, 1'b0, 1'b1, 3'd3};
        tbl[6]  = '{8'h00, 2'd1, 1'b0, 1'b1, 3'd3};
        tbl[7]  = '{8'h02, 2'd1, 1'b0, 1'b1, 3'd4};
        tbl[8]  = '{8'h00, 2'd1, 1'b0, 1'b1, 3'd4};
        tbl[9]  = '{8'h00, 2'd1, 1'b1, 1'b0, 3'd0};
        tbl[10] = '{8'h00, 2'd0, 1'b0, 1'b0, 3'd0};

        resetN = 1'b0; event_in = '0; mode = 2'd0; clear = 1'b0; tick = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_led", 32'(led_a), 32'h0);
        chk("reset_cnt", 32'(cnt_b), 32'h0);
        chk("reset_any", 32'(any_a), 32'h0);
        resetN = 1'b1;

        // STRETCH, pulse on ch0 at cycle 10, ticks at cycles 100 and 200
        for (int c = 0; c < 250; c++) begin
            if (c == 11)  chk("stretch_on",   32'(led_a[0]), 32'h1);
            if (c == 11)  chk("stretch_cnt",  32'(ch_cnt(cnt_a, 0)), 32'h1);
            if (c == 200) chk("stretch_last", 32'(led_a[0]), 32'h1);
            if (c == 201) chk("stretch_off",  32'(led_a[0]), 32'h0);
            step((c == 10) ? 8'h01 : 8'h00, 2'd0, 1'b0, (c > 0) && (c % 100 == 0));
        end

        // Retrigger on ch3 coincident with a tick while the hold-2 timer is 1
        step(8'h08, 2'd0, 1'b0, 1'b0);
        step(8'h00, 2'd0, 1'b0, 1'b1);
        step(8'h08, 2'd0, 1'b0, 1'b1);
        chk("retrig_cnt", 32'(ch_cnt(cnt_a, 3)), 32'h2);
        step(8'h00, 2'd0, 1'b0, 1'b1);
        chk("retrig_lit", 32'(led_a[3]), 32'h1);
        step(8'h00, 2'd0, 1'b0, 1'b1);
        chk("retrig_off", 32'(led_a[3]), 32'h0);

        step(8'h00, 2'd2, 1'b1, 1'b0);
        foreach (tbl[k]) begin
            step(tbl[k].ev, tbl[k].md, tbl[k].clr, 1'b0);
            chk($sformatf("tbl%0d_led1", k), 32'(led_a[1]), 32'(tbl[k].exp_led1));
            chk($sformatf("tbl%0d_cnt1", k), 32'(ch_cnt(cnt_a, 1)), 32'(tbl[k].exp_cnt1));
        end

        // Level hold counts once, then pulses saturate at 7
        repeat (50) step(8'h04, 2'd0, 1'b0, 1'b0);
        chk("level_cnt", 32'(ch_cnt(cnt_a, 2)), 32'h1);
        for (int p = 0; p < 10; p++) begin
            step(8'h00, 2'd0, 1'b0, 1'b0);
            step(8'h04, 2'd0, 1'b0, 1'b0);
        end
        step(8'h00, 2'd0, 1'b0, 1'b0);
        chk("sat_cnt", 32'(ch_cnt(cnt_a, 2)), 32'h7);

        // BLINK on ch4, ticks every 10 cycles
        step(8'h00, 2'd3, 1'b1, 1'b0);
        step(8'h10, 2'd3, 1'b0, 1'b0);
        for (int c = 1; c <= 60; c++) step(8'h00, 2'd3, 1'b0, (c % 10) == 0);
        chk("blink_off_h4", 32'(led_b[4]), 32'h0);
        chk("blink_any_h4", 32'(any_b), 32'h0);

        // Async reset mid-hold, then a still-high input re-fires
        step(8'h20, 2'd0, 1'b0, 1'b0);
        step(8'h20, 2'd0, 1'b0, 1'b0);
        chk("hold_lit", 32'(led_a[5]), 32'h1);
        resetN = 1'b0;
        #1;
        chk("async_led", 32'(led_a), 32'h0);
        chk("async_any", 32'(any_b), 32'h0);
        chk("async_cnt", 32'(cnt_a), 32'h0);
        model_reset();
        step(8'h20, 2'd0, 1'b0, 1'b0);
        resetN = 1'b1;
        step(8'h20, 2'd0, 1'b0, 1'b0);
        chk("refire_cnt", 32'(ch_cnt(cnt_a, 5)), 32'h1);
        chk("refire_led", 32'(led_a[5]), 32'h1);

        // Clear together with an event on ch6: event lost, no re-fire while held
        step(8'h40, 2'd1, 1'b1, 1'b0);
        chk("clr_evt_cnt", 32'(ch_cnt(cnt_a, 6)), 32'h0);
        chk("clr_evt_led", 32'(led_a[6]), 32'h0);
        step(8'h40, 2'd0, 1'b0, 1'b0);
        chk("clr_hold_cnt", 32'(ch_cnt(cnt_a, 6)), 32'h0);
        chk("clr_hold_led", 32'(led_a[6]), 32'h0);

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            logic [CH-1:0] ev;
            logic [1:0]    md;
            ev = CH'($urandom & $urandom);
            md = ($urandom_range(0, 15) == 0) ? 2'($urandom) : mode;
            step(ev, md, $urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0);
        end
        #1;
        check_all();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/debug_led_bank.md
# debug_led_bank

Parametrised multi-channel debug indicator driving board LEDs from single-cycle or level event signals anywhere in the game logic. Each channel edge-detects its event input and shows it on an LED according to a runtime mode: stretch for N seconds, sticky, toggle or blink. Each channel also keeps a saturating event counter for SignalTap/7-segment readout. Fully synchronous to `clk`. The hold time uses a `tick` strobe from the one-second prescaler, not a second clock.

## Interface
- CHANNELS, 8, number of independent event/LED channels (1..32)
- HOLD_TICKS, 2, tick strobes an LED stays lit after the last event in STRETCH/BLINK (>=1)
- CNT_W, 8, width of each per-channel event counter
- clk  in  1  system clock
- resetN  in  1  reset resetN, asynchronous, active-low
- tick  in  1  one-clk strobe, e.g. once per second; paces hold timers and blink phase
- event_in  in  CHANNELS  per-channel event request, synchronous to clk, rising edge counts
- mode  in  2  00 STRETCH, 01 STICKY, 10 TOGGLE, 11 BLINK; global, sampled every cycle
- clear  in  1  synchronous clear of all channel state and counters
- led_out  out  CHANNELS  LED drive, active-high
- event_cnt  out  CHANNELS*CNT_W  channel i counter at bits [i*CNT_W +: CNT_W]
- any_active  out  1  OR of all led_out bits

## Operation
- Edge detect: prev[i] is registered from event_in[i] and resets to 0. An event is evt[i] = event_in[i] & ~prev[i]. A level held high counts exactly once. It re-arms only after event_in[i] has been low for at least 1 cycle.
- Per-channel state:
  - timer[i], width $clog2(HOLD_TICKS+1)
  - latch[i], 1 bit
  - cnt[i], CNT_W bits
  - All reset to 0.
- Shared blink phase register resets to 1 and inverts on every tick.
- Timer rules, priority high to low:
  - clear -> 0.
  - evt[i] -> load HOLD_TICKS. Retrigger reloads the timer even when it is nonzero.
  - tick with timer != 0 -> decrement.
  - Otherwise hold.
- The timer runs in every mode.
- Latch rules, priority high to low:
  - clear -> 0.
  - evt[i] with mode STICKY -> 1.
  - evt[i] with mode TOGGLE -> ~latch.
  - Otherwise hold. Events in STRETCH and BLINK leave the latch unchanged.
- Counter: clear -> 0. Otherwise evt[i] increments it, saturating at 2^CNT_W-1 with no wrap.
- led_out[i] is combinational from registered state and the current mode:
  - STRETCH: timer != 0
  - STICKY and TOGGLE: latch
  - BLINK: (timer != 0) & phase
- A mode change takes effect on led_out in the same cycle. It never modifies stored state.
- clear does not affect prev or phase.

## Timing
- Reset values:
  - led_out = 0, event_cnt = 0, any_active = 0
  - prev = 0, timer = 0, latch = 0, phase = 1
- Latency: if event_in rises before edge k, evt is seen at edge k. Then led_out and event_cnt update right after edge k, a latency of 1 clk.
- STRETCH duration: the LED goes dark on the HOLD_TICKS-th tick strictly after the event's cycle. On-time is in (HOLD_TICKS-1, HOLD_TICKS] tick periods.
- evt and tick in the same cycle: the reload wins, so the tick is not counted against the new hold.
- Simultaneous events on several channels are all handled in the same cycle, independently.
- clear together with evt: clear wins. Counter, latch and timer end at 0, and the event is lost. prev still updates, so holding the input high does not re-fire.
- Asserting resetN mid-hold drops led_out to 0 immediately (asynchronously). After release, a still-high event_in produces a fresh event, because prev = 0.

## Test plan
- STRETCH, HOLD_TICKS=2, tick every 100 clk. Pulse event_in[0] for 1 clk at cycle 10. Required: led_out[0]=1 from cycle 11 until the second tick (cycle 200), 0 after; cnt[0]=1.
- Retrigger plus coincident tick. Event on ch3 in the same cycle as a tick while timer=1. Required: timer=2, LED stays lit through 2 more ticks; cnt[3] increments by 1.
- TOGGLE and STICKY. TOGGLE: 3 events on ch1 -> led_out[1]=1, then 0, then 1. Switch to STICKY and do 1 event -> stays 1. Assert clear -> 0 and cnt[1]=0.
- Level and saturation, CNT_W=3. Hold event_in[2] high for 50 clk -> cnt=1. Then 10 separate pulses -> cnt=7, does not wrap to 0.
- BLINK. Event on ch4, HOLD_TICKS=4. Required: led_out[4] follows phase (1,0,1,0 per tick period), then 0 after the 4th tick; any_active mirrors it.
- Reset mid-hold and clear vs event. Assert resetN=0 with the LED lit -> all outputs 0 asynchronously. Then clear and evt in the same cycle -> cnt=0, LED stays 0.
